// File: rtl/booth_mul_seq_if.sv
// Request/result and shared-adder signals of the sequential Booth multiplier.
// The slave side is the multiplier; the master side is its requester plus the external CLA.
interface booth_mul_seq_if;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_s;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mcand, mplier, add_s, add_cout,
    input  add_a, add_b, add_cin, busy, done, hi, lo
  );

  modport slave (
    input  start, mcand, mplier, add_s, add_cout,
    output add_a, add_b, add_cin, busy, done, hi, lo
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Radix-2 Booth signed 32x32 multiplier, one step per cycle over 32 cycles.
// Add/subtract of the partial product is done on a shared external CLA.
module booth_mul_seq (
  input  logic           clk,
  input  logic           rst_n,
  booth_mul_seq_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] m_q, q_q, a_q, hi_q, lo_q;
  logic        q1_q;
  logic [4:0]  step_q;
  logic [32:0] ext_sum;
  logic [31:0] a_next, q_next;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (step_q == 5'd31) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M via ~M + 1.
  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (state_q == StRun) begin
      bus.add_a = a_q;
      case ({q_q[0], q1_q})
        2'b01: bus.add_b = m_q;
        2'b10: begin
          bus.add_b   = ~m_q;
          bus.add_cin = 1'b1;
        end
        default: bus.add_b = '0;
      endcase
    end
  end

  // Recovered sign bit keeps the 33-bit sum exact, e.g. when M = 0x80000000.
  assign ext_sum = {bus.add_a[31] ^ bus.add_b[31] ^ bus.add_cout, bus.add_s};
  assign a_next  = ext_sum[32:1];
  assign q_next  = {ext_sum[0], q_q[31:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      q1_q    <= 1'b0;
      step_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            m_q    <= bus.mcand;
            q_q    <= bus.mplier;
            a_q    <= '0;
            q1_q   <= 1'b0;
            step_q <= '0;
          end
        end
        StRun: begin
          a_q    <= a_next;
          q_q    <= q_next;
          q1_q   <= q_q[0];
          step_q <= step_q + 5'd1;
          if (step_q == 5'd31) begin
            hi_q <= a_next;
            lo_q <= q_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed-vector bench for booth_mul_seq; models the external CLA as a plain adder.
module tb_booth_mul_seq;
  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   misses  = 0;

  booth_mul_seq_if bus ();

  booth_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      misses++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is at a falling edge. disturb_at >= 0 pulses a second start with other
  // operands after that many RUN edges.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int disturb_at);
    int   n;
    bit   seen;
    bit   busy_ok;
    logic [31:0] b0;
    logic        cin0;
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    b0   = b[0] ? ~a : 32'd0;
    cin0 = b[0];
    check({tag, " busy@E0"}, {63'd0, bus.busy}, 64'd1);
    check({tag, " step0 add"}, {bus.add_a, bus.add_b}, {32'd0, b0});
    check({tag, " step0 cin"}, {63'd0, bus.add_cin}, {63'd0, cin0});
    seen    = 1'b0;
    busy_ok = 1'b1;
    n       = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      n         = i;
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (i == disturb_at) begin
        bus.start  = 1'b1;
        bus.mcand  = 32'd9;
        bus.mplier = 32'd9;
      end
    end
    check({tag, " done seen"}, {63'd0, seen}, 64'd1);
    // E0 plus 32 RUN edges: done appears after the 33rd edge counting E0.
    check({tag, " latency"}, 64'(n), 64'd32);
    check({tag, " busy held"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " product"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    check({tag, " idle adder"}, {bus.add_a, bus.add_b}, 64'd0);
    check({tag, " hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    #3;
    check("reset outs", {bus.hi, bus.lo}, 64'd0);
    check("reset flags", {61'd0, bus.busy, bus.done, bus.add_cin}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("3x5", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, -1);
    @(negedge clk);
    run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, -1);
    @(negedge clk);
    run_op("min2", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1);
    @(negedge clk);
    run_op("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, -1);
    @(negedge clk);
    run_op("7xm3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
    @(negedge clk);
    run_op("shift16", 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, -1);
    @(negedge clk);
    run_op("restart", 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 10);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 32'd3;
    bus.mplier = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst flags", {62'd0, bus.busy, bus.done}, 64'd0);
    check("midrst outs", {bus.hi, bus.lo}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst no done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("postrst", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/booth_mul_seq.md
BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have port: mcand  input  32  signed multiplicand; captured on accepted start.
REQ-005 SHALL have port: mplier  input  32  signed multiplier; captured on accepted start.
REQ-006 SHALL have port: add_a  output  32  operand A driven to shared external 32-bit CLA.
REQ-007 SHALL have port: add_b  output  32  operand B driven to shared external CLA.
REQ-008 SHALL have port: add_cin  output  1  carry-in driven to shared external CLA.
REQ-009 SHALL have port: add_s  input  32  sum returned combinationally from external CLA, same cycle.
REQ-010 SHALL have port: add_cout  input  1  carry-out returned from external CLA.
REQ-011 SHALL have port: busy  output  1  high while iterating.
REQ-012 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: hi  output  32  upper half of 64-bit signed product.
REQ-014 SHALL have port: lo  output  32  lower half of 64-bit signed product.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after step 31, DONE->IDLE unconditionally next cycle.
REQ-016 SHALL on accepted start: M<=mcand, Q<=mplier, A<=0, q_1<=0, step<=0.
REQ-017 SHALL ignore start in RUN and DONE; captured operands unaffected by later mcand/mplier changes.
REQ-018 SHALL in RUN drive add_a=A and select by {Q[0],q_1}: 01 -> add_b=M, add_cin=0; 10 -> add_b=~M, add_cin=1; 00/11 -> add_b=0, add_cin=0.
REQ-019 SHALL form 33-bit extended sum E={add_a[31]^add_b[31]^add_cout, add_s} so M=0x80000000 is exact.
REQ-020 SHALL each RUN cycle arithmetic-shift right: A<=E[32:1], Q<={E[0],Q[31:1]}, q_1<=Q[0], step<=step+1.
REQ-021 SHALL perform exactly 32 steps (step 0..31); step counter 5 bits, wraps to 0 on RUN exit.
REQ-022 SHALL on the edge leaving step 31 load hi<=A_next, lo<=Q_next; hi/lo hold until next completion.
REQ-023 SHALL drive busy=1 only in RUN; done=1 only in DONE.
REQ-024 SHALL drive add_a=0, add_b=0, add_cin=0 in IDLE and DONE.
REQ-025 SHALL have latency: start sampled at edge E0; busy high E0..E32; done high cycle after E32; hi/lo valid with done.
REQ-026 SHALL treat operands as two's-complement signed; result exact for all 2^64 operand pairs.

Reset
REQ-027 SHALL on rst_n low immediately (asynchronously) force IDLE, busy=0, done=0, hi=0, lo=0, A=Q=M=0, q_1=0, step=0.
REQ-028 SHALL abandon any in-flight operation on reset mid-RUN; no done pulse produced for it.
REQ-029 SHALL accept start on first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL cover: mcand=3, mplier=5 -> done 33 edges after start, hi=0x00000000, lo=0x0000000F.
REQ-031 SHALL cover: mcand=0xFFFFFFFF, mplier=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001.
REQ-032 SHALL cover: mcand=0x80000000, mplier=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-033 SHALL cover: mcand=0x7FFFFFFF, mplier=0x80000000 -> hi=0xC0000000, lo=0x80000000.
REQ-034 SHALL cover: second start pulsed at step 10 with different operands -> ignored, first result unchanged, single done pulse.
REQ-035 SHALL cover: rst_n low at step 10 -> busy=0, done=0, hi=lo=0 at once; subsequent 3*5 completes correctly.
